uart_rx_param: RTL
==================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; even and >= 4.
REQ-003 Parameter PARITY_EN, default 1, 1 = a parity bit follows the data bits.
REQ-004 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-005 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 enable  input  1  receiver enable; 0 holds the receiver idle.
REQ-009 data_in  input  1  serial line; idle high; LSB first.
REQ-010 data_bus  output  DATA_W  last received data word.
REQ-011 valid  output  1  data_bus, parity_err and frame_err hold an unconsumed frame.
REQ-012 ready  input  1  consumer accepts the frame when valid=1 and ready=1.
REQ-013 busy  output  1  high while the FSM is in any state other than IDLE.
REQ-014 parity_err  output  1  parity mismatch on the frame presented with valid.
REQ-015 frame_err  output  1  a stop bit sampled low on the frame presented with valid.
REQ-016 overrun  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-017 data_in shall pass through a 2-flop synchroniser; all logic shall use the synchronised value rx_s.
REQ-018 FSM states shall be IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE -> START when enable=1 and rx_s falls from 1 to 0; the bit counter and the cycle counter clear.
REQ-020 START shall resample rx_s after CLKS_PER_BIT/2 cycles; if rx_s=0 go to DATA, otherwise go to IDLE (false start) with no flags set.
REQ-021 DATA, PARITY and STOP shall each sample rx_s once, CLKS_PER_BIT cycles after the previous sample (the bit centre).
REQ-022 DATA shall shift in DATA_W bits LSB first, then go to PARITY if PARITY_EN=1, else to STOP.
REQ-023 The expected parity bit shall be XOR(data) XOR PARITY_ODD; parity_err_next = sampled parity bit != expected.
REQ-024 STOP shall sample STOP_BITS stop bits; any sample of 0 sets frame_err_next.
REQ-025 After the final stop sample, the FSM shall go to IDLE in the next cycle, so a start edge can be accepted immediately after the stop bit.
REQ-026 On frame completion with valid=0, or with valid=1 and ready=1 in the same cycle: load data_bus, parity_err and frame_err; valid=1 on the next cycle.
REQ-027 On frame completion with valid=1 and ready=0: keep the old data_bus and flags, discard the new frame, pulse overrun for exactly 1 cycle.
REQ-028 valid shall fall on the cycle after valid=1 and ready=1, unless REQ-026 reloads it in that same cycle.
REQ-029 enable=0 in any non-IDLE state shall abort to IDLE on the next cycle; no valid and no overrun are produced; pending valid/data_bus are unaffected.
REQ-030 With PARITY_EN=0, parity_err shall always be 0.
REQ-031 Latency: valid rises 1 cycle after the last stop-bit centre sample, plus the 2-cycle synchroniser delay.

Reset
REQ-032 While rst=1: state=IDLE, counters=0, data_bus=0, valid=0, busy=0, parity_err=0, frame_err=0, overrun=0, and synchroniser flops=1.
REQ-033 rst asserted mid-frame shall discard the partial frame; after release the receiver waits for a new falling edge.

Verification (DATA_W=8, CLKS_PER_BIT=16, PARITY_EN=1, PARITY_ODD=0, STOP_BITS=1)
REQ-034 Bench: frame 0xAE with parity 1 and stop 1, ready=1 -> data_bus=0xAE, valid pulse, parity_err=0, frame_err=0.
REQ-035 Bench: frame 0x55 with parity bit 1 (wrong; expected 0) -> data_bus=0x55, valid=1, parity_err=1.
REQ-036 Bench: 0xA5 with stop bit driven 0 -> frame_err=1; a correct 0x3C sent next -> frame_err=0.
REQ-037 Bench: data_in low for 4 cycles, then high -> busy goes high then returns to 0, valid stays 0.
REQ-038 Bench: ready=0, frames 0x11 then 0x22 back-to-back -> data_bus=0x11, overrun pulses once; with ready=1 valid clears.
REQ-039 Bench: rst=1 during data bit 4 of 0xF0, then a clean 0x0F -> outputs 0 during reset, then data_bus=0x0F with no errors.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 2-flop synchroniser, mid-bit sampling FSM,
// optional parity, 1 or 2 stop bits, valid/ready output with overrun pulse.
module uart_rx_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              data_in,
  input  logic              ready,
  output logic [DATA_W-1:0] data_bus,
  output logic              valid,
  output logic              busy,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  // state  | meaning
  // IDLE   | waiting for a falling edge on rx_s
  // START  | half-bit wait, confirm start bit still low
  // DATA   | sample DATA_W data bits at bit centres, LSB first
  // PARITY | sample parity bit
  // STOP   | sample STOP_BITS stop bits, complete frame on the last one

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] HALF_TC   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_TC   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);
  localparam logic          PAR_ON    = (PARITY_EN != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_next;
  logic              rx_meta, rx_s, rx_q;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              par_bad, fe_acc;
  logic              tick, done;

  // rx_q is the previous synchronised value, used only for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      rx_meta <= data_in;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    tick       = (state != IDLE) && (cnt == ((state == START) ? HALF_TC : FULL_TC));
    case (state)
      IDLE:   if (enable && rx_q && !rx_s) state_next = START;
      START:  if (tick) state_next = rx_s ? IDLE : DATA;
      DATA:   if (tick && bit_cnt == LAST_DATA) state_next = PAR_ON ? PARITY : STOP;
      PARITY: if (tick) state_next = STOP;
      STOP:   if (tick && bit_cnt == LAST_STOP) begin
                state_next = IDLE;
                done       = 1'b1;
              end
      default: state_next = IDLE;
    endcase
    if (!enable && state != IDLE) begin
      state_next = IDLE;
      done       = 1'b0;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par_bad <= 1'b0;
      fe_acc  <= 1'b0;
    end else begin
      cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
      if (state == IDLE) begin
        bit_cnt <= '0;
        par_bad <= 1'b0;
        fe_acc  <= 1'b0;
      end else if (tick && state != START) begin
        bit_cnt <= (state_next != state) ? '0 : bit_cnt + 1'b1;
      end
      if (tick && state == DATA) shift <= {rx_s, shift[DATA_W-1:1]};
      if (tick && state == PARITY) par_bad <= (rx_s != ((^shift) ^ ODD));
      if (tick && state == STOP && !rx_s) fe_acc <= 1'b1;
    end
  end

  // A completed frame is only dropped when the previous one is still held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_bus   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= done && valid && !ready;
      if (done && (!valid || ready)) begin
        data_bus   <= shift;
        parity_err <= PAR_ON && par_bad;
        frame_err  <= fe_acc || !rx_s;
        valid      <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
